keyboard_keymap_ctl: RTL and testbench

Parametrised PS/2 scan-code decoder (set 2) that turns the byte stream from the PS/2 receiver into per-key held levels plus one-cycle press/release event pulses for a configurable table of keys. It understands extended (E0) and break (F0) prefixes, swallows the 8-byte Pause sequence, and aborts stalled prefixes on a timeout. It sits between the PS/2 receiver and the game/character control logic. It replaces fixed 3-key decoding with a key table chosen at instantiation.

---
 rtl/keyboard_pkg.sv | 30 +++
 rtl/ps2_seq_fsm.sv | 112 +++++++++++
 rtl/keyboard_keymap_ctl.sv | 82 ++++++++
 tb/tb_keyboard_keymap_ctl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared PS/2 set-2 scan-code constants, decoder state type and common key codes.
// A key code is {extended, code}: bit 8 is set for E0-prefixed keys.
package keyboard_pkg;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_PAUSE      = 8'hE1;
   localparam int         PAUSE_TAIL_LEN = 7;

   typedef logic [8:0] keycode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE_SKIP
   } ps2_state_e;

   localparam keycode_t KEY_W     = 9'h0_1D;
   localparam keycode_t KEY_A     = 9'h0_1C;
   localparam keycode_t KEY_S     = 9'h0_1B;
   localparam keycode_t KEY_D     = 9'h0_23;
   localparam keycode_t KEY_SPACE = 9'h0_29;
   localparam keycode_t KEY_UP    = 9'h1_75;
   localparam keycode_t KEY_DOWN  = 9'h1_72;
   localparam keycode_t KEY_LEFT  = 9'h1_6B;
   localparam keycode_t KEY_RIGHT = 9'h1_74;

endpackage

// File: rtl/ps2_seq_fsm.sv
// Prefix tracker for the PS/2 byte stream: folds E0/F0 prefixes into one decoded code,
// drops the Pause sequence, and abandons a stalled prefix after TIMEOUT_CYCLES.
module ps2_seq_fsm
   import keyboard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done_tick,
   input  logic       clear_all,
   output logic       code_valid,
   output logic       code_ext,
   output logic       code_break,
   output logic [7:0] code,
   output logic       seq_abort
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   ps2_state_e    state_q;
   logic [2:0]    skip_q;
   logic [CW-1:0] cnt_q;
   logic          seq_abort_q;
   logic          byte_en;

   assign byte_en   = rx_done_tick & ~clear_all;
   assign code      = rx_data;
   assign seq_abort = seq_abort_q;

   // The final byte is decoded in its own cycle so the key registers update on the next edge.
   always_comb begin
      code_valid = 1'b0;
      code_ext   = 1'b0;
      code_break = 1'b0;
      if (byte_en) begin
         case (state_q)
            ST_IDLE:    code_valid = (rx_data != PS2_EXT) && (rx_data != PS2_BREAK) &&
                                     (rx_data != PS2_PAUSE);
            ST_EXT: begin
               code_valid = (rx_data != PS2_EXT) && (rx_data != PS2_BREAK);
               code_ext   = 1'b1;
            end
            ST_BRK: begin
               code_valid = 1'b1;
               code_break = 1'b1;
            end
            ST_EXT_BRK: begin
               code_valid = 1'b1;
               code_ext   = 1'b1;
               code_break = 1'b1;
            end
            default: code_valid = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         skip_q      <= 3'd0;
         cnt_q       <= '0;
         seq_abort_q <= 1'b0;
      end else begin
         seq_abort_q <= 1'b0;
         if (clear_all) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
            cnt_q   <= '0;
         end else if (rx_done_tick) begin
            cnt_q <= '0;
            case (state_q)
               ST_IDLE: begin
                  if (rx_data == PS2_EXT) begin
                     state_q <= ST_EXT;
                  end else if (rx_data == PS2_BREAK) begin
                     state_q <= ST_BRK;
                  end else if (rx_data == PS2_PAUSE) begin
                     state_q <= ST_PAUSE_SKIP;
                     skip_q  <= 3'(PAUSE_TAIL_LEN);
                  end
               end
               ST_EXT: begin
                  if (rx_data == PS2_BREAK) begin
                     state_q <= ST_EXT_BRK;
                  end else if (rx_data != PS2_EXT) begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_PAUSE_SKIP: begin
                  skip_q <= skip_q - 3'd1;
                  if (skip_q == 3'd1) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (state_q != ST_IDLE) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_q     <= ST_IDLE;
               skip_q      <= 3'd0;
               cnt_q       <= '0;
               seq_abort_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/keyboard_keymap_ctl.sv
// PS/2 set-2 decoder top: matches decoded codes against the key table and keeps
// per-key held levels plus one-cycle press/release pulses.
module keyboard_keymap_ctl
   import keyboard_pkg::*;
#(
   parameter int                      NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {9'h1_6B, 9'h0_23, 9'h0_1C, 9'h0_1D},
   parameter int                      TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_done_tick,
   input  logic                clear_all,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                seq_abort
);

   logic                code_valid;
   logic                code_ext;
   logic                code_break;
   logic [7:0]          code;
   logic [NUM_KEYS-1:0] key_hit;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] press_q, press_d;
   logic [NUM_KEYS-1:0] release_q, release_d;

   ps2_seq_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_seq (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done_tick(rx_done_tick),
      .clear_all   (clear_all),
      .code_valid  (code_valid),
      .code_ext    (code_ext),
      .code_break  (code_break),
      .code        (code),
      .seq_abort   (seq_abort)
   );

   // Duplicate table entries simply hit together.
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
      assign key_hit[gi] = code_valid && (KEY_CODES[gi*9 +: 9] == {code_ext, code});
   end

   always_comb begin
      held_d    = held_q;
      press_d   = '0;
      release_d = '0;
      if (clear_all) begin
         held_d    = '0;
         release_d = held_q;
      end else if (code_break) begin
         held_d    = held_q & ~key_hit;
         release_d = held_q & key_hit;
      end else begin
         held_d  = held_q | key_hit;
         press_d = key_hit & ~held_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         held_q    <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         held_q    <= held_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign key_held    = held_q;
   assign key_press   = press_q;
   assign key_release = release_q;

endmodule

// File: tb/tb_keyboard_keymap_ctl.sv
// Self-checking bench for keyboard_keymap_ctl: directed scenarios plus a random byte
// stream, all compared against a byte-sequence reference model.
module tb_keyboard_keymap_ctl;

   localparam int NK = 4;
   localparam int TO = 16;
   localparam logic [NK*9-1:0] KC = {9'h1_6B, 9'h0_23, 9'h0_1C, 9'h0_1D};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_done_tick = 1'b0;
   logic          clear_all = 1'b0;
   logic [NK-1:0] key_held, key_press, key_release;
   logic          seq_abort;

   keyboard_keymap_ctl #(
      .NUM_KEYS(NK), .KEY_CODES(KC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
      .clear_all(clear_all), .key_held(key_held), .key_press(key_press),
      .key_release(key_release), .seq_abort(seq_abort)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: remembers which prefixes of the current sequence have been seen.
   logic [NK-1:0] m_held = '0, m_press = '0, m_rel = '0;
   bit m_ext = 0, m_brk = 0;
   int m_pause = 0;

   wire [3*NK:0] obs_vec = {key_held, key_press, key_release, seq_abort};

   function automatic logic [3*NK:0] exp_vec();
      return {m_held, m_press, m_rel, 1'b0};
   endfunction

   function automatic void model_reset_seq();
      m_ext = 0; m_brk = 0; m_pause = 0;
   endfunction

   function automatic void model_apply(bit ext, bit brk, logic [7:0] b);
      logic [NK*9-1:0] tbl = KC;
      for (int i = 0; i < NK; i++) begin
         if (tbl[i*9 +: 9] == {ext, b}) begin
            if (brk) begin
               if (m_held[i]) m_rel[i] = 1'b1;
               m_held[i] = 1'b0;
            end else begin
               if (!m_held[i]) m_press[i] = 1'b1;
               m_held[i] = 1'b1;
            end
         end
      end
      m_ext = 0; m_brk = 0;
   endfunction

   function automatic void model_byte(logic [7:0] b);
      m_press = '0; m_rel = '0;
      if (m_pause > 0) m_pause--;
      else if (m_brk) model_apply(m_ext, 1, b);
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1 && !m_ext) m_pause = 7;
      else model_apply(m_ext, 0, b);
   endfunction

   task automatic drive_byte(input logic [7:0] b);
      rx_data = b; rx_done_tick = 1'b1;
      model_byte(b);
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
   endtask

   task automatic drive_clear(input logic [7:0] b, input logic tick);
      rx_data = b; rx_done_tick = tick; clear_all = 1'b1;
      m_press = '0; m_rel = m_held; m_held = '0;
      model_reset_seq();
      @(posedge clk); #1;
      clear_all = 1'b0; rx_done_tick = 1'b0;
   endtask

   task automatic idle_cycle();
      m_press = '0; m_rel = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_vec++;
      if (obs_vec !== '0) begin
         n_err++; $display("FAIL reset: got %h expected 0", obs_vec);
      end
   endtask

   task automatic test_typematic();
      logic [7:0] seq [3] = '{8'h1D, 8'h1D, 8'h1D};
      for (int k = 0; k < 3; k++) begin
         drive_byte(seq[k]);
         n_vec++;
         if (obs_vec !== exp_vec() || key_held[0] !== 1'b1 || key_press[0] !== (k == 0)) begin
            n_err++; $display("FAIL typematic byte%0d: got %h expected %h", k, obs_vec, exp_vec());
         end
      end
      idle_cycle();
      n_vec++;
      if (obs_vec !== exp_vec() || key_press !== '0) begin
         n_err++; $display("FAIL typematic_idle: got %h expected %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_break();
      logic [7:0] seq [4] = '{8'hF0, 8'h1D, 8'hF0, 8'h1C};
      for (int k = 0; k < 4; k++) begin
         drive_byte(seq[k]);
         n_vec++;
         if (obs_vec !== exp_vec() || key_release !== ((k == 1) ? 4'b0001 : 4'b0000)) begin
            n_err++; $display("FAIL break byte%0d: got %h expected %h", k, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_extended();
      logic [7:0] seq [6] = '{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B, 8'h6B};
      logic [NK-1:0] want [6] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
      for (int k = 0; k < 6; k++) begin
         drive_byte(seq[k]);
         n_vec++;
         if (obs_vec !== exp_vec() || key_held !== want[k]) begin
            n_err++; $display("FAIL extended byte%0d: got %h expected %h", k, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      drive_byte(8'h1C);
      for (int k = 0; k < 8; k++) begin
         drive_byte(seq[k]);
         n_vec++;
         if (obs_vec !== exp_vec() || key_held !== 4'b0010) begin
            n_err++; $display("FAIL pause byte%0d: got %h expected held 0010", k, obs_vec);
         end
      end
      drive_byte(8'h23);
      n_vec++;
      if (obs_vec !== exp_vec() || key_held !== 4'b0110) begin
         n_err++; $display("FAIL pause_after: got %h expected %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_timeout();
      int first = -1;
      int pulses = 0;
      drive_byte(8'hE0);
      for (int j = 1; j <= 3 * TO; j++) begin
         @(posedge clk); #1;
         if (seq_abort === 1'b1) begin
            pulses++;
            if (first < 0) first = j;
         end
      end
      model_reset_seq();
      m_press = '0; m_rel = '0;
      n_vec++;
      if (first != TO || pulses != 1) begin
         n_err++; $display("FAIL timeout_abort: first at %0d count %0d, expected at %0d count 1",
                           first, pulses, TO);
      end
      drive_byte(8'h1D);
      n_vec++;
      if (obs_vec !== exp_vec() || key_held !== 4'b0111) begin
         n_err++; $display("FAIL timeout_next: got %h expected %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_clear_all();
      drive_byte(8'hF0);
      drive_byte(8'h1C);
      drive_clear(8'h1C, 1'b1);
      n_vec++;
      if (obs_vec !== exp_vec() || key_held !== 4'b0000 || key_release !== 4'b0101) begin
         n_err++; $display("FAIL clear_all: got %h expected %h", obs_vec, exp_vec());
      end
      idle_cycle();
      n_vec++;
      if (obs_vec !== '0) begin
         n_err++; $display("FAIL clear_idle: got %h expected 0", obs_vec);
      end
   endtask

   task automatic test_rst_mid();
      drive_byte(8'h1D);
      drive_byte(8'hF0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_held = '0; m_press = '0; m_rel = '0;
      model_reset_seq();
      n_vec++;
      if (obs_vec !== '0) begin
         n_err++; $display("FAIL rst_mid: got %h expected 0", obs_vec);
      end
      drive_byte(8'h1D);
      n_vec++;
      if (obs_vec !== exp_vec() || key_press !== 4'b0001) begin
         n_err++; $display("FAIL rst_then_make: got %h expected %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pool [10] = '{8'h1D, 8'h1C, 8'h23, 8'h6B, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h1B, 8'h29};
      logic [7:0] b;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            drive_clear(8'($urandom), 1'($urandom));
         end else begin
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            drive_byte(b);
         end
         n_vec++;
         if (obs_vec !== exp_vec()) begin
            n_err++; $display("FAIL random step%0d: got %h expected %h", n, obs_vec, exp_vec());
         end
         repeat ($urandom_range(0, 2)) begin
            idle_cycle();
            n_vec++;
            if (obs_vec !== exp_vec()) begin
               n_err++; $display("FAIL random_idle step%0d: got %h expected %h", n, obs_vec, exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_typematic();
      test_break();
      test_extended();
      test_pause();
      test_timeout();
      test_clear_all();
      test_rst_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
